// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module : aes_pkg
// Brief  : Shared types, sizes and the PKCS#7 fill helper for the AES-ECB feeder.
// Rev    : 1.0
// ============================================================================
package aes_pkg;

    localparam int AES_BLK_BYTES = 16;
    localparam int CHUNK_BYTES   = 32;

    typedef logic [127:0] aes_key_t;
    typedef logic [255:0] aes_chunk_t;

    typedef enum logic [1:0] {
        S_FILL = 2'd0,
        S_OUT  = 2'd1,
        S_XPAD = 2'd2
    } pk_state_e;

    typedef struct packed {
        aes_chunk_t chunk;
        logic [1:0] nblk;
    } pad_res_t;

    // Bytes n..31 receive the pad; a short tail pads only the first block.
    function automatic pad_res_t pkcs7_fill(input aes_chunk_t chunk, input logic [5:0] n);
        pad_res_t   r;
        logic [7:0] pv;
        r.chunk = chunk;
        if (n < 6'd16)       pv = {2'b00, 6'd16 - n};
        else if (n == 6'd16) pv = 8'h10;
        else                 pv = {2'b00, 6'd32 - n};
        for (int i = 0; i < CHUNK_BYTES; i++) begin
            if (i >= int'(n)) begin
                if (n < 6'd16 && i >= AES_BLK_BYTES) r.chunk[255-8*i -: 8] = 8'h00;
                else                                 r.chunk[255-8*i -: 8] = pv;
            end
        end
        r.nblk = (n < 6'd16) ? 2'd1 : 2'd2;
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_pad_fill.sv
`default_nettype none
// ============================================================================
// Module : aes_pad_fill
// Brief  : Combinational tail fill of a 32-byte chunk holding n message bytes.
// Rev    : 1.0
// ============================================================================
module aes_pad_fill
    import aes_pkg::*;
#(
    parameter bit PAD_EN = 1'b1
) (
    input  aes_chunk_t buf_i,
    input  logic [5:0] n_i,
    output aes_chunk_t chunk_o,
    output logic [1:0] nblk_o,
    output logic       xpad_o
);

    generate
        if (PAD_EN) begin : g_pkcs7
            pad_res_t w_res;
            always_comb begin
                w_res   = pkcs7_fill(buf_i, n_i);
                chunk_o = w_res.chunk;
                nblk_o  = w_res.nblk;
                xpad_o  = (n_i == 6'd32);
            end
        end else begin : g_zero
            always_comb begin
                chunk_o = buf_i;
                for (int i = 0; i < CHUNK_BYTES; i++) begin
                    if (i >= int'(n_i)) chunk_o[255-8*i -: 8] = 8'h00;
                end
                nblk_o = (n_i <= 6'd16) ? 2'd1 : 2'd2;
                xpad_o = 1'b0;
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/aes_ecb_block_packer.sv
`default_nettype none
// ============================================================================
// Module : aes_ecb_block_packer
// Brief  : Packs a 32-bit word stream into padded 256-bit chunks for AES-ECB.
// Rev    : 1.0
// ============================================================================
module aes_ecb_block_packer
    import aes_pkg::*;
#(
    parameter bit PAD_EN = 1'b1,
    parameter int KEY_W  = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_last,
    input  logic [2:0]       in_nbytes,
    input  logic [KEY_W-1:0] key,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [255:0]     out_text,
    output logic [KEY_W-1:0] out_key,
    output logic [1:0]       out_nblk,
    output logic             out_last,
    output logic             err_nbytes
);

    localparam aes_chunk_t XPAD_CHUNK = {{16{8'h10}}, 128'h0};

    pk_state_e        state_q;
    aes_chunk_t       buf_q;
    aes_chunk_t       buf_d;
    logic [4:0]       cnt_q;
    logic [5:0]       n_d;
    logic [2:0]       inc_d;
    logic             nb_bad;
    logic             acc;
    logic             msg_open_q;
    logic             xpad_pend_q;
    logic             err_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             out_last_q;
    logic [1:0]       nblk_q;
    logic [KEY_W-1:0] key_q;

    aes_chunk_t       pad_chunk;
    logic [1:0]       pad_nblk;
    logic             pad_xpad;

    assign acc = in_valid && in_ready_q;

    always_comb begin
        nb_bad = (in_nbytes == 3'd0) || (in_nbytes > 3'd4);
        inc_d  = (in_last && !nb_bad) ? in_nbytes : 3'd4;
        n_d    = {1'b0, cnt_q} + {3'b000, inc_d};
        buf_d  = buf_q;
        for (int j = 0; j < 4; j++) begin
            buf_d[255-8*(int'(cnt_q)+j) -: 8] = in_data[31-8*j -: 8];
        end
    end

    aes_pad_fill #(
        .PAD_EN (PAD_EN)
    ) u_pad (
        .buf_i   (buf_d),
        .n_i     (n_d),
        .chunk_o (pad_chunk),
        .nblk_o  (pad_nblk),
        .xpad_o  (pad_xpad)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_FILL;
            buf_q       <= '0;
            cnt_q       <= '0;
            msg_open_q  <= 1'b0;
            xpad_pend_q <= 1'b0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            nblk_q      <= 2'd0;
            key_q       <= '0;
        end else begin
            case (state_q)
                S_FILL: begin
                    if (acc) begin
                        if (!msg_open_q) key_q <= key;
                        if (in_last && nb_bad) err_q <= 1'b1;
                        if (in_last || n_d == 6'd32) begin
                            state_q     <= S_OUT;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                            cnt_q       <= '0;
                        end else begin
                            cnt_q <= n_d[4:0];
                        end
                        if (in_last) begin
                            buf_q       <= pad_chunk;
                            nblk_q      <= pad_nblk;
                            out_last_q  <= !pad_xpad;
                            xpad_pend_q <= pad_xpad;
                            msg_open_q  <= 1'b0;
                        end else begin
                            buf_q      <= buf_d;
                            nblk_q     <= 2'd2;
                            out_last_q <= 1'b0;
                            msg_open_q <= 1'b1;
                        end
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        if (xpad_pend_q) begin
                            state_q    <= S_XPAD;
                            buf_q      <= XPAD_CHUNK;
                            nblk_q     <= 2'd1;
                            out_last_q <= 1'b1;
                        end else begin
                            state_q     <= S_FILL;
                            buf_q       <= '0;
                            cnt_q       <= '0;
                            nblk_q      <= 2'd0;
                            out_last_q  <= 1'b0;
                            out_valid_q <= 1'b0;
                            in_ready_q  <= 1'b1;
                        end
                    end
                end
                S_XPAD: begin
                    if (out_ready) begin
                        state_q     <= S_FILL;
                        buf_q       <= '0;
                        cnt_q       <= '0;
                        nblk_q      <= 2'd0;
                        out_last_q  <= 1'b0;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        xpad_pend_q <= 1'b0;
                    end
                end
                default: state_q <= S_FILL;
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_text   = buf_q;
    assign out_key    = key_q;
    assign out_nblk   = nblk_q;
    assign out_last   = out_last_q;
    assign err_nbytes = err_q;

endmodule
`default_nettype wire

// File: doc/aes_ecb_block_packer.md
Name: aes_ecb_block_packer

Overview:
- Upstream feeder for the AES-ECB encrypt stage, which consumes a 128-bit key and a 256-bit text (two AES blocks) and produces the ciphertext.
- Accepts a byte-oriented message as a stream of 32-bit words with valid/ready/last.
- Packs the words big-endian into 256-bit chunks and applies PKCS#7 padding at a 16-byte block size.
- Presents each chunk, with the key sampled for that message, on a valid/ready output to the encrypt stage.

Parameters:
- PAD_EN, 1, 1: PKCS#7 padding applied. 0: the tail is zero-filled and no extra pad block is emitted.
- KEY_W, 128, key width; fixed by the AES-128 stage.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high; sampled on the rising edge of clk.
- in_valid  in  1  input word valid.
- in_ready  out  1  packer can accept a word.
- in_data  in  32  message bytes; first byte in [31:24].
- in_last  in  1  final word of the message.
- in_nbytes  in  3  valid bytes in the last word, 1..4, left-aligned. Ignored when in_last=0.
- key  in  128  key; sampled on the first accepted word of each message.
- out_valid  out  1  chunk valid.
- out_ready  in  1  encrypt stage accepts the chunk.
- out_text  out  256  packed chunk; message byte 0 in [255:248].
- out_key  out  128  key for this chunk.
- out_nblk  out  2  valid AES blocks in out_text, 1 or 2. The lower 128 bits are zero when this is 1.
- out_last  out  1  final chunk of the message.
- err_nbytes  out  1  sticky flag: in_last was accepted with in_nbytes equal to 0 or greater than 4. That word is treated as 4 bytes. Cleared only by rst.

Behaviour:
- Reset values: all outputs 0 except in_ready=1. State S_FILL, byte count 0, buffer cleared.
- rst mid-message or mid-output discards all partial data. Any chunk being held on the output is dropped without a handshake.
- States: S_FILL, S_OUT, S_XPAD.
- S_FILL:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready, the word is written at byte offset cnt (0..28, always a multiple of 4). cnt advances by 4, or by in_nbytes on the last word.
  - The first accepted word of a message (cnt=0 and no message open) latches key into out_key.
- Transitions out of S_FILL, with n = bytes in the chunk after the accepted word:
  - Not last, n=32: go to S_OUT with nblk=2, last=0. The message continues at cnt=0 of the next chunk, keeping the same out_key.
  - Last, n<16: bytes n..15 = (16-n), bytes 16..31 = 0, nblk=1, last=1, go to S_OUT.
  - Last, n=16: bytes 16..31 = 0x10, nblk=2, last=1.
  - Last, 16<n<32: bytes n..31 = (32-n), nblk=2, last=1.
  - Last, n=32: nblk=2, last=0, go to S_OUT, and set xpad_pending.
  - With PAD_EN=0: the tail is zero, nblk = n≤16 ? 1 : 2, last=1, and xpad_pending is never set.
- Pad bytes are written combinationally into the registered buffer in the same cycle as the last word is accepted.
- S_OUT:
  - out_valid=1, in_ready=0. out_text, out_key, out_nblk and out_last are held stable until out_valid&&out_ready.
  - On that handshake: if xpad_pending, go to S_XPAD; otherwise clear the buffer and cnt and go to S_FILL.
- S_XPAD:
  - out_valid=1, out_text = {16 bytes of 0x10, 128'h0}, nblk=1, last=1, same out_key.
  - On handshake: go to S_FILL and clear xpad_pending.
- Latency: out_valid rises on the clock edge that accepts the completing word, i.e. it is visible the next cycle. No overlap of fill and drain.
- Throughput: one full chunk per 9 cycles with out_ready held high.
- Simultaneous in_last with a full chunk is covered by the n=32 rule. out_ready asserted while out_valid=0 has no effect.

Decomposition:
- Package aes_pkg holds:
  - AES_BLK_BYTES=16, CHUNK_BYTES=32.
  - typedef aes_key_t (logic [127:0]) and aes_chunk_t (logic [255:0]).
  - Enum pk_state_e {S_FILL, S_OUT, S_XPAD}.
  - Function pkcs7_fill(chunk, n), returning the chunk and nblk.
- One sub-module, aes_pad_fill: combinational. Inputs: buffer and n. Outputs: padded chunk, nblk, xpad flag. It is reusable by the decrypt-side unpadder bench.

Test Plan:
- NIST 32-byte message:
  - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c; words 6bc1bee2,2e409f96,e93d7e11,7393172a,ae2d8a57,1e03ac9c,9eb76fac,45af8e51, with last on the 8th word and nbytes=4.
  - Response: chunk 1 = 6bc1...8e51, nblk=2, last=0. Chunk 2 = {0x10×16, 128'h0}, nblk=1, last=1. out_key equals the key on both chunks.
- 3-byte message: one word 61626300, last, nbytes=3 -> out_text = 616263 followed by 0d×13, lower 128 bits 0, nblk=1, last=1.
- 20-byte message: five words, last with nbytes=4 -> bytes 20..31 = 0x0c, nblk=2, last=1; a single chunk.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> all outputs stable, in_ready=0, and in_valid words are not accepted. The handshake on the 6th cycle returns to S_FILL with in_ready=1.
- Reset mid-fill:
  - Stimulus: 3 words accepted, then rst for 1 cycle.
  - Response: out_valid=0, in_ready=1, err_nbytes=0. A following 3-byte message produces exactly the 3-byte result above.
- Error flag: last word with nbytes=0 -> err_nbytes=1, the word is treated as 4 bytes, and the flag holds until rst.
